// File: rtl/ft245_device_model_if.sv
// ft245_device_model_if: FIFO-bus handshake strobes between the FPGA master and the FTDI device model.
//   rxf, txe : device -> master status (active-high)
//   wr, rd, oe : master -> device strobes (active-high)
interface ft245_device_model_if;
    logic rxf;
    logic txe;
    logic wr;
    logic rd;
    logic oe;
    modport master (input rxf, txe, output wr, rd, oe);
    modport slave (output rxf, txe, input wr, rd, oe);
endinterface

// File: rtl/ft245_device_model.sv
// ft245_device_model: FTDI-side model of the 32-bit synchronous FIFO bus with RX/TX buffers and packet gaps.
//   usb_clk, rst          : clock, asynchronous active-high reset
//   bus (slave)           : rxf/txe status out, wr/rd/oe strobes in
//   usb_data, usb_be      : bidirectional data bus and byte enables
//   host_tx_*             : host stream into the RX buffer (host -> FPGA)
//   host_rx_*             : host stream out of the TX buffer (FPGA -> host)
//   overrun/underrun/proto_err : sticky error flags, cleared only by rst
module ft245_device_model #(
    parameter int DEPTH_LOG2 = 4,
    parameter int PKT_WORDS  = 8,
    parameter int TXE_GAP    = 3
) (
    input  logic                usb_clk,
    input  logic                rst,
    ft245_device_model_if.slave bus,
    inout  wire  [31:0]         usb_data,
    inout  wire  [3:0]          usb_be,
    input  logic [31:0]         host_tx_data,
    input  logic                host_tx_valid,
    output logic                host_tx_ready,
    output logic [31:0]         host_rx_data,
    output logic [3:0]          host_rx_be,
    output logic                host_rx_valid,
    input  logic                host_rx_ready,
    output logic                overrun,
    output logic                underrun,
    output logic                proto_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;
    localparam int PW = $clog2(PKT_WORDS + 1);
    localparam int GW = $clog2(TXE_GAP + 2);

    typedef enum logic {OPEN, GAP} state_t;

    logic [31:0] rx_mem [DEPTH];
    logic [35:0] tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic [CW-1:0] rx_count, rx_count_next, tx_count, tx_count_next;
    logic rx_push, rx_pop, tx_push, tx_pop;
    state_t state, state_next;
    logic [PW-1:0] pkt_cnt, pkt_next;
    logic [GW-1:0] gap_cnt, gap_next;

    assign host_tx_ready = rx_count < CW'(DEPTH);
    assign host_rx_valid = tx_count != '0;
    assign rx_push = host_tx_valid && host_tx_ready;
    assign rx_pop = bus.rd && bus.oe && bus.rxf;
    assign tx_push = bus.wr && bus.txe;
    assign tx_pop = host_rx_valid && host_rx_ready;
    assign rx_count_next = rx_count + CW'(rx_push) - CW'(rx_pop);
    assign tx_count_next = tx_count + CW'(tx_push) - CW'(tx_pop);
    assign {host_rx_be, host_rx_data} = tx_mem[tx_rp];

    // The device only drives while the master asks for output and is not itself writing,
    // so a protocol-violating wr&&oe never produces bus contention.
    assign usb_data = (bus.oe && !bus.wr) ? rx_mem[rx_rp] : 32'bz;
    assign usb_be = (bus.oe && !bus.wr) ? 4'b1111 : 4'bz;

    always_ff @(posedge usb_clk) begin
        if (rx_push) rx_mem[rx_wp] <= host_tx_data;
        if (tx_push) tx_mem[tx_wp] <= {usb_be, usb_data};
    end

    always_comb begin
        state_next = state;
        pkt_next = pkt_cnt;
        gap_next = gap_cnt;
        if (state == OPEN) begin
            if (tx_push) begin
                if (pkt_cnt == PW'(PKT_WORDS - 1)) begin
                    pkt_next = '0;
                    if (TXE_GAP != 0) begin
                        state_next = GAP;
                        gap_next = GW'(TXE_GAP == 0 ? 0 : TXE_GAP - 1);
                    end
                end else begin
                    pkt_next = pkt_cnt + 1'b1;
                end
            end
        end else begin
            if (gap_cnt == '0) state_next = OPEN;
            else gap_next = gap_cnt - 1'b1;
        end
    end

    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            rx_wp <= '0;
            rx_rp <= '0;
            tx_wp <= '0;
            tx_rp <= '0;
            rx_count <= '0;
            tx_count <= '0;
            state <= OPEN;
            pkt_cnt <= '0;
            gap_cnt <= '0;
            bus.rxf <= 1'b0;
            bus.txe <= 1'b0;
            overrun <= 1'b0;
            underrun <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop) tx_rp <= tx_rp + 1'b1;
            rx_count <= rx_count_next;
            tx_count <= tx_count_next;
            state <= state_next;
            pkt_cnt <= pkt_next;
            gap_cnt <= gap_next;
            // Status flags look at next-state counts so they are exact one edge after any change.
            bus.rxf <= rx_count_next != '0;
            bus.txe <= (tx_count_next < CW'(DEPTH)) && (state_next == OPEN);
            if (bus.wr && !bus.txe) overrun <= 1'b1;
            if (bus.rd && !bus.rxf) underrun <= 1'b1;
            if ((bus.wr && bus.oe) || (bus.rd && !bus.oe)) proto_err <= 1'b1;
        end
    end
endmodule
